// File: rtl/qei_pkg.sv
// Definitions shared by the quadrature decoder stage and its downstream
// velocity/period measurement logic.
package qei_pkg;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_BWD = 1'b0;

  localparam int QEI_VEL_W = 16;
  localparam int QEI_PER_W = 24;

  typedef enum logic {
    PER_IDLE  = 1'b0,
    PER_ARMED = 1'b1
  } per_state_e;

endpackage

// File: rtl/qei_period_timer.sv
// Step-to-step period measurement: counts clk edges between two consecutive
// same-direction steps and flags a stall when the counter tops out.
module qei_period_timer
  import qei_pkg::*;
#(
  parameter int PER_W = QEI_PER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step_en,
  input  logic             step_dir,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             stalled
);

  localparam logic [PER_W-1:0] CNT_MAX = '1;
  localparam logic [PER_W-1:0] CNT_ONE = PER_W'(1);

  per_state_e       state_reg, state_next;
  logic [PER_W-1:0] cnt_reg, cnt_next;
  logic [PER_W-1:0] period_reg, period_next;
  logic             dir_reg, dir_next;
  logic             period_valid_reg, period_valid_next;
  logic             stalled_reg, stalled_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= PER_IDLE;
      cnt_reg          <= '0;
      period_reg       <= '0;
      dir_reg          <= DIR_FWD;
      period_valid_reg <= 1'b0;
      stalled_reg      <= 1'b1;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      period_reg       <= period_next;
      dir_reg          <= dir_next;
      period_valid_reg <= period_valid_next;
      stalled_reg      <= stalled_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    period_next       = period_reg;
    dir_next          = dir_reg;
    period_valid_next = 1'b0;
    stalled_next      = stalled_reg;
    if (clr) begin
      state_next   = PER_IDLE;
      cnt_next     = '0;
      period_next  = '0;
      stalled_next = 1'b1;
    end else begin
      case (state_reg)
        PER_IDLE: begin
          stalled_next = 1'b1;
          cnt_next     = '0;
          if (step_en) begin
            state_next = PER_ARMED;
            dir_next   = step_dir;
            cnt_next   = CNT_ONE;
          end
        end
        PER_ARMED: begin
          if (step_en) begin
            // A reversal restarts the measurement without publishing.
            if (step_dir == dir_reg) begin
              period_next       = cnt_reg;
              period_valid_next = 1'b1;
              stalled_next      = 1'b0;
            end
            dir_next = step_dir;
            cnt_next = CNT_ONE;
          end else if (cnt_reg == CNT_MAX) begin
            state_next   = PER_IDLE;
            cnt_next     = '0;
            stalled_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: state_next = PER_IDLE;
      endcase
    end
  end

  assign period       = period_reg;
  assign period_valid = period_valid_reg;
  assign stalled      = stalled_reg;

endmodule

// File: rtl/qei_velocity.sv
// Windowed signed velocity (net steps per gate window) plus step-to-step
// period measurement for the quadrature decoder output.
module qei_velocity
  import qei_pkg::*;
#(
  parameter int GATE_CYCLES = 100000,
  parameter int VEL_W       = QEI_VEL_W,
  parameter int PER_W       = QEI_PER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_en,
  input  logic             step_dir,
  input  logic             clr,
  output logic [VEL_W-1:0] vel,
  output logic             vel_valid,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             stalled
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0] GATE_ONE  = GW'(1);
  // Symmetric saturation limits keep |vel| representable in both directions.
  localparam logic signed [VEL_W-1:0] VMAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VMIN = -VMAX;
  localparam logic signed [VEL_W-1:0] VONE = VEL_W'(1);

  logic [GW-1:0]           gate_cnt_reg;
  logic signed [VEL_W-1:0] acc_reg, acc_sum;
  logic signed [VEL_W-1:0] vel_reg;
  logic                    vel_valid_reg;
  logic                    terminal;

  assign terminal = (gate_cnt_reg == GATE_LAST);

  always_comb begin
    acc_sum = acc_reg;
    if (step_en) begin
      if (step_dir == DIR_FWD) begin
        if (acc_reg != VMAX) acc_sum = acc_reg + VONE;
      end else if (step_dir == DIR_BWD) begin
        if (acc_reg != VMIN) acc_sum = acc_reg - VONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt_reg  <= '0;
      acc_reg       <= '0;
      vel_reg       <= '0;
      vel_valid_reg <= 1'b0;
    end else begin
      vel_valid_reg <= 1'b0;
      if (clr) begin
        gate_cnt_reg <= '0;
        acc_reg      <= '0;
        vel_reg      <= '0;
      end else if (terminal) begin
        // A step on the terminal cycle is folded into the closing window.
        gate_cnt_reg  <= '0;
        acc_reg       <= '0;
        vel_reg       <= acc_sum;
        vel_valid_reg <= 1'b1;
      end else begin
        gate_cnt_reg <= gate_cnt_reg + GATE_ONE;
        acc_reg      <= acc_sum;
      end
    end
  end

  assign vel       = vel_reg;
  assign vel_valid = vel_valid_reg;

  qei_period_timer #(
    .PER_W(PER_W)
  ) u_period (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .step_en     (step_en),
    .step_dir    (step_dir),
    .period      (period),
    .period_valid(period_valid),
    .stalled     (stalled)
  );

endmodule

// File: tb/tb_qei_velocity.sv
// Directed bench: two instances share stimulus, a wide one (16/24 bit) and a
// narrow one (4/6 bit) that exercises velocity saturation and period stall.
module tb_qei_velocity;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic step_en = 1'b0;
  logic step_dir = 1'b0;

  logic signed [15:0] vel_a;
  logic               vel_valid_a;
  logic [23:0]        period_a;
  logic               pv_a;
  logic               stalled_a;

  logic signed [3:0]  vel_b;
  logic               vel_valid_b;
  logic [5:0]         period_b;
  logic               pv_b;
  logic               stalled_b;

  int n_vec = 0;
  int n_bad = 0;
  int pv_seen = 0;
  int n;

  always #5 clk = ~clk;

  qei_velocity #(.GATE_CYCLES(64), .VEL_W(16), .PER_W(24)) dut_a (
    .clk(clk), .rst(rst), .step_en(step_en), .step_dir(step_dir), .clr(clr),
    .vel(vel_a), .vel_valid(vel_valid_a), .period(period_a),
    .period_valid(pv_a), .stalled(stalled_a)
  );

  qei_velocity #(.GATE_CYCLES(64), .VEL_W(4), .PER_W(6)) dut_b (
    .clk(clk), .rst(rst), .step_en(step_en), .step_dir(step_dir), .clr(clr),
    .vel(vel_b), .vel_valid(vel_valid_b), .period(period_b),
    .period_valid(pv_b), .stalled(stalled_b)
  );

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pv_a) pv_seen++;
  endtask

  task automatic step(input logic d);
    step_en  = 1'b1;
    step_dir = d;
    tick();
    step_en  = 1'b0;
    step_dir = ~d;
  endtask

  task automatic wait_vel(output int cnt);
    logic done;
    done = 1'b0;
    cnt = 0;
    while (!done && cnt < 200) begin
      tick();
      cnt++;
      done = vel_valid_a;
    end
    if (!done) chk("vel_valid_timeout", 32'(0), 32'(1));
    else chk("vel_valid_b_aligned", 32'(vel_valid_b), 32'(1));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vel", 32'(vel_a), 0);
    chk("rst_vel_valid", 32'(vel_valid_a), 0);
    chk("rst_period", 32'(period_a), 0);
    chk("rst_pv", 32'(pv_a), 0);
    chk("rst_stalled", 32'(stalled_a), 1);
    rst = 1'b0;

    // Idle windows
    wait_vel(n);
    chk("idle_first_window", n, 64);
    chk("idle_vel0", 32'(vel_a), 0);
    wait_vel(n);
    chk("idle_second_window", n, 64);
    chk("idle_vel1", 32'(vel_a), 0);
    chk("idle_stalled", 32'(stalled_a), 1);
    chk("idle_no_pv", pv_seen, 0);

    // Windowed velocity
    repeat (10) step(1'b1);
    wait_vel(n);
    chk("vel_fwd10_a", 32'(vel_a), 10);
    chk("vel_fwd10_b_sat", 32'(vel_b), 7);
    wait_vel(n);
    chk("vel_empty", 32'(vel_a), 0);
    repeat (5) step(1'b0);
    wait_vel(n);
    chk("vel_bwd5_a", 32'(vel_a), -5);
    chk("vel_bwd5_b", 32'(vel_b), -5);

    // Period: forward steps every 20 cycles, then a reversal
    step(1'b1);
    chk("per_first_no_pv", 32'(pv_a), 0);
    for (int i = 0; i < 3; i++) begin
      repeat (19) tick();
      step(1'b1);
      chk("per_fwd_pv", 32'(pv_a), 1);
      chk("per_fwd_20", 32'(period_a), 20);
      chk("per_fwd_20_b", 32'(period_b), 20);
      chk("per_fwd_not_stalled", 32'(stalled_a), 0);
    end
    repeat (19) tick();
    step(1'b0);
    chk("per_reversal_no_pv", 32'(pv_a), 0);
    chk("per_reversal_hold", 32'(period_a), 20);
    repeat (19) tick();
    step(1'b0);
    chk("per_bwd_pv", 32'(pv_a), 1);
    chk("per_bwd_20", 32'(period_a), 20);

    // Saturation on the narrow instance
    wait_vel(n);
    repeat (12) step(1'b1);
    wait_vel(n);
    chk("sat_fwd_b", 32'(vel_b), 7);
    chk("sat_fwd_a", 32'(vel_a), 12);
    repeat (12) step(1'b0);
    wait_vel(n);
    chk("sat_bwd_b", 32'(vel_b), -7);
    chk("sat_bwd_a", 32'(vel_a), -12);

    // Stall on the 6-bit period counter
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_stalled_b", 32'(stalled_b), 1);
    step(1'b1);
    repeat (9) tick();
    step(1'b1);
    chk("stall_pre_pv_b", 32'(pv_b), 1);
    chk("stall_pre_per_b", 32'(period_b), 10);
    repeat (62) tick();
    chk("stall_not_yet_b", 32'(stalled_b), 0);
    tick();
    chk("stall_b", 32'(stalled_b), 1);
    chk("stall_period_hold_b", 32'(period_b), 10);
    chk("stall_a_running", 32'(stalled_a), 0);
    step(1'b1);
    chk("stall_rearm_no_pv_b", 32'(pv_b), 0);
    chk("stall_long_per_a", 32'(period_a), 64);
    repeat (9) tick();
    step(1'b1);
    chk("stall_after_pv_b", 32'(pv_b), 1);
    chk("stall_after_per_b", 32'(period_b), 10);
    chk("stall_after_clear_b", 32'(stalled_b), 0);

    // Step on terminal cycle belongs to the closing window
    wait_vel(n);
    repeat (5) tick();
    step(1'b1);
    repeat (57) tick();
    step(1'b1);
    chk("term_vel_valid", 32'(vel_valid_a), 1);
    chk("term_vel", 32'(vel_a), 2);
    step(1'b1);
    wait_vel(n);
    chk("term_next_window", 32'(vel_a), 1);

    // Asynchronous reset mid-window
    repeat (3) step(1'b1);
    repeat (10) tick();
    rst = 1'b1;
    #2;
    chk("arst_vel", 32'(vel_a), 0);
    chk("arst_period", 32'(period_a), 0);
    chk("arst_stalled", 32'(stalled_a), 1);
    chk("arst_vel_valid", 32'(vel_valid_a), 0);
    rst = 1'b0;
    wait_vel(n);
    chk("arst_first_window", n, 64);
    chk("arst_vel_after", 32'(vel_a), 0);

    // clr overrides a simultaneous step
    repeat (3) step(1'b1);
    wait_vel(n);
    chk("preclr_vel", 32'(vel_a), 3);
    repeat (2) step(1'b1);
    repeat (5) tick();
    clr = 1'b1;
    step_en = 1'b1;
    step_dir = 1'b1;
    tick();
    clr = 1'b0;
    step_en = 1'b0;
    chk("clr_vel", 32'(vel_a), 0);
    chk("clr_period", 32'(period_a), 0);
    chk("clr_stalled", 32'(stalled_a), 1);
    chk("clr_no_pv", 32'(pv_a), 0);
    chk("clr_no_vel_valid", 32'(vel_valid_a), 0);
    wait_vel(n);
    chk("clr_gate_restart", n, 64);
    chk("clr_acc_cleared", 32'(vel_a), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/qei_velocity.md
# qei_velocity

Downstream consumer of the quadrature decoder: takes the decoder's per-step strobe and direction and produces a signed velocity (net steps per fixed gate window) and a step-to-step period measurement. It sits between the QEI counter stage and the output mux. Host logic can use the period at low speed and the windowed velocity at high speed.

## Interface

- `GATE_CYCLES`, 100000: gate window length in `clk` cycles (1 ms at 100 MHz); must be ≥ 2.
- `VEL_W`, 16: width of signed velocity output.
- `PER_W`, 24: width of unsigned period counter/output.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `step_en` in 1: one-cycle strobe, decoder registered one quadrature step this cycle.
- `step_dir` in 1: direction of step, 1 = forward (+1), 0 = backward (−1); valid only with `step_en`.
- `clr` in 1: synchronous clear of measurement state.
- `vel` out VEL_W: signed net steps in last completed window, two's complement.
- `vel_valid` out 1: one-cycle pulse when `vel` updates.
- `period` out PER_W: `clk` cycles between last two consecutive same-direction steps.
- `period_valid` out 1: one-cycle pulse when `period` updates.
- `stalled` out 1: no step seen within 2^PER_W−1 cycles, or no reference step yet.

## Operation

- Gate counter runs 0..GATE_CYCLES−1 continuously; terminal cycle = GATE_CYCLES−1.
- Accumulator (signed, VEL_W) adds ±1 per `step_en`; saturates at +(2^(VEL_W−1)−1) and −(2^(VEL_W−1)−1); never wraps.
- Terminal cycle: `vel` ← accumulator plus this cycle's step (saturated), accumulator ← 0, `vel_valid` pulses. A step on the terminal cycle belongs to the closing window.
- Period FSM states: IDLE, ARMED.
  - IDLE: `stalled`=1, period counter held at 0. `step_en` → ARMED, latch `step_dir`, counter ← 1.
  - ARMED: counter increments each cycle with no step.
  - ARMED + `step_en` with same direction: `period` ← counter, `period_valid` pulses, counter ← 1, `stalled` ← 0.
  - ARMED + `step_en` with opposite direction (reversal): no publish; latch new dir, counter ← 1.
  - ARMED, counter reaches 2^PER_W−1 with no step: → IDLE, `stalled` ← 1; `period` keeps last value.
- `clr`: accumulator, gate counter, period counter ← 0; FSM → IDLE; `vel`, `period` ← 0; `stalled` ← 1; no valid pulses that cycle. `clr` overrides a simultaneous step or terminal cycle.
- `step_dir` ignored when `step_en`=0.

## Timing

- Reset values: `vel`=0, `vel_valid`=0, `period`=0, `period_valid`=0, `stalled`=1; FSM IDLE, counters 0. Outputs take these values asynchronously on `rst` assertion, mid-window included.
- First window closes GATE_CYCLES cycles after `rst` deasserts; `vel_valid` asserted in the cycle after the terminal cycle (outputs registered, 1-cycle latency).
- `period_valid`/`period` registered: visible the cycle after the qualifying `step_en`.
- Period measured as number of rising edges from one step strobe to the next; steps on consecutive cycles give `period`=1.
- `vel` and `period` hold between pulses.

## Structure

- Shared package `qei_pkg`: `DIR_FWD`/`DIR_BWD` constants, period FSM state enum, default widths (`QEI_VEL_W`, `QEI_PER_W`), shared with decoder stage.
- One sub-module `qei_period_timer`: period FSM, period counter, `stalled`. Gate counter and saturating accumulator stay in top.

## Test plan

- Reset then idle (GATE_CYCLES=64): `vel`=0, `stalled`=1, `vel_valid` pulses every 64 cycles with `vel`=0, no `period_valid`.
- 10 forward steps inside one window → `vel`=+10 at next pulse; following empty window → `vel`=0; 5 backward steps → `vel`=−5.
- Forward steps every 20 cycles → `period`=20 on every step after the first, `stalled`=0. Reversal step → no pulse; next backward step 20 cycles later → `period`=20.
- Saturation (VEL_W=4): 12 forward steps in a window → `vel`=+7; 12 backward → `vel`=−7.
- Stall (PER_W=6): one step then 63 idle cycles → `stalled`=1. Next step → no `period_valid`; step 10 cycles after that → `period`=10.
- Boundaries: step on terminal cycle counted in closing window. `clr` with simultaneous step → all zero, `stalled`=1. `rst` mid-window → outputs at reset values before the next clock edge.
